// File: rtl/mem_arbiter.sv
// Memory-side responder for cpu16: arbitrates instruction/data reads onto one RAM read
// port and data/debug writes onto one write port, with a one-cycle ready pulse per transaction.
module mem_arbiter #(
    parameter int                 DATA_W  = 16,
    parameter logic [DATA_W-1:0]  RD_FILL = 16'hEEEE
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       ins_rd_addr,
    input  logic              ins_rd_req,
    output logic              ins_rd_rdy,
    output logic [DATA_W-1:0] ins_rd_data,
    input  logic [15:0]       dat_rw_addr,
    input  logic              dat_rd_req,
    output logic              dat_rd_rdy,
    output logic [DATA_W-1:0] dat_rd_data,
    input  logic              dat_wr_req,
    input  logic [DATA_W-1:0] dat_wr_data,
    output logic              dat_wr_rdy,
    input  logic              dbg_we,
    input  logic [15:0]       dbg_waddr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [15:0]       mem_raddr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              sram_we,
    output logic              vram_we,
    output logic              ctrl_we
);

    typedef enum logic [1:0] {
        REG_NONE,
        REG_SRAM,
        REG_VRAM,
        REG_CTRL
    } region_t;

    function automatic region_t decode_region(input logic [3:0] nib);
        case (nib)
            4'h0:    return REG_SRAM;
            4'h8:    return REG_VRAM;
            4'hF:    return REG_CTRL;
            default: return REG_NONE;
        endcase
    endfunction

    logic ins_busy, dat_busy, last_ins;
    logic vld_p1, src_p1, sram_p1, sram_p2;

    logic              ins_elig, dat_elig, grant_ins, grant_dat, grant, grant_sram;
    logic [15:0]       grant_addr;
    logic              wr_accept, wr_en;
    logic [15:0]       wr_addr;
    logic [DATA_W-1:0] wr_data;
    region_t           wr_region;

    always_comb begin
        ins_elig   = ins_rd_req && !ins_busy;
        dat_elig   = dat_rd_req && !dat_wr_req && !dat_busy;
        // On contention the source that did not win last time is served.
        grant_ins  = ins_elig && (!dat_elig || !last_ins);
        grant_dat  = dat_elig && !grant_ins;
        grant      = grant_ins || grant_dat;
        grant_addr = grant_ins ? ins_rd_addr : dat_rw_addr;
        grant_sram = (decode_region(grant_addr[15:12]) == REG_SRAM);

        // Debug strobes cannot stall, so they always own the write port.
        wr_accept  = dat_wr_req && !dat_wr_rdy && !dbg_we;
        wr_en      = dbg_we || wr_accept;
        wr_addr    = dbg_we ? dbg_waddr : dat_rw_addr;
        wr_data    = dbg_we ? dbg_wdata : dat_wr_data;
        wr_region  = decode_region(wr_addr[15:12]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ins_busy   <= 1'b0;
            dat_busy   <= 1'b0;
            last_ins   <= 1'b0;
            vld_p1     <= 1'b0;
            src_p1     <= 1'b0;
            sram_p1    <= 1'b0;
            sram_p2    <= 1'b0;
            ins_rd_rdy <= 1'b0;
            dat_rd_rdy <= 1'b0;
            dat_wr_rdy <= 1'b0;
            mem_re     <= 1'b0;
            mem_raddr  <= '0;
            mem_waddr  <= '0;
            mem_wdata  <= '0;
            sram_we    <= 1'b0;
            vram_we    <= 1'b0;
            ctrl_we    <= 1'b0;
        end else begin
            // Issue stage
            vld_p1  <= grant;
            src_p1  <= grant_dat;
            sram_p1 <= grant_sram;
            mem_re  <= grant && grant_sram;
            if (grant) begin
                mem_raddr <= grant_addr;
                last_ins  <= grant_ins;
            end

            // Return stage
            ins_rd_rdy <= vld_p1 && !src_p1;
            dat_rd_rdy <= vld_p1 && src_p1;
            sram_p2    <= sram_p1;

            // A source stays busy through its rdy cycle so a held req is not re-sampled.
            if (grant_ins)
                ins_busy <= 1'b1;
            else if (ins_rd_rdy)
                ins_busy <= 1'b0;
            if (grant_dat)
                dat_busy <= 1'b1;
            else if (dat_rd_rdy)
                dat_busy <= 1'b0;

            // Write port
            dat_wr_rdy <= wr_accept;
            sram_we    <= wr_en && (wr_region == REG_SRAM);
            vram_we    <= wr_en && (wr_region == REG_VRAM);
            ctrl_we    <= wr_en && (wr_region == REG_CTRL);
            if (wr_en) begin
                mem_waddr <= wr_addr;
                mem_wdata <= wr_data;
            end
        end
    end

    assign ins_rd_data = sram_p2 ? mem_rdata : RD_FILL;
    assign dat_rd_data = sram_p2 ? mem_rdata : RD_FILL;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous SRAM model on the memory ports.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ins_rd_addr;
    logic        ins_rd_req;
    logic        ins_rd_rdy;
    logic [15:0] ins_rd_data;
    logic [15:0] dat_rw_addr;
    logic        dat_rd_req;
    logic        dat_rd_rdy;
    logic [15:0] dat_rd_data;
    logic        dat_wr_req;
    logic [15:0] dat_wr_data;
    logic        dat_wr_rdy;
    logic        dbg_we;
    logic [15:0] dbg_waddr;
    logic [15:0] dbg_wdata;
    logic [15:0] mem_raddr;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic [15:0] mem_waddr;
    logic [15:0] mem_wdata;
    logic        sram_we;
    logic        vram_we;
    logic        ctrl_we;

    int n_vec = 0;
    int n_err = 0;

    mem_arbiter dut (
        .clk(clk), .reset(reset),
        .ins_rd_addr(ins_rd_addr), .ins_rd_req(ins_rd_req),
        .ins_rd_rdy(ins_rd_rdy), .ins_rd_data(ins_rd_data),
        .dat_rw_addr(dat_rw_addr), .dat_rd_req(dat_rd_req),
        .dat_rd_rdy(dat_rd_rdy), .dat_rd_data(dat_rd_data),
        .dat_wr_req(dat_wr_req), .dat_wr_data(dat_wr_data), .dat_wr_rdy(dat_wr_rdy),
        .dbg_we(dbg_we), .dbg_waddr(dbg_waddr), .dbg_wdata(dbg_wdata),
        .mem_raddr(mem_raddr), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .sram_we(sram_we), .vram_we(vram_we), .ctrl_we(ctrl_we)
    );

    always #5 clk = ~clk;

    logic [15:0] ram [0:4095];
    always @(posedge clk) begin
        if (sram_we) ram[mem_waddr[11:0]] <= mem_wdata;
        if (mem_re)  mem_rdata <= ram[mem_raddr[11:0]];
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int ins_cnt;
    int dat_cnt;

    initial begin
        mem_rdata   = '0;
        reset       = 1'b1;
        ins_rd_addr = '0; ins_rd_req = 1'b0;
        dat_rw_addr = '0; dat_rd_req = 1'b0;
        dat_wr_req  = 1'b0; dat_wr_data = '0;
        dbg_we      = 1'b0; dbg_waddr = '0; dbg_wdata = '0;
        repeat (3) tick();
        check("rst_ins_rdy", {15'd0, ins_rd_rdy}, 16'd0);
        check("rst_dat_rdy", {15'd0, dat_rd_rdy}, 16'd0);
        check("rst_wr_rdy",  {15'd0, dat_wr_rdy}, 16'd0);
        check("rst_mem_re",  {15'd0, mem_re}, 16'd0);
        check("rst_we",      {13'd0, sram_we, vram_we, ctrl_we}, 16'd0);
        check("rst_raddr",   mem_raddr, 16'h0000);
        check("rst_waddr",   mem_waddr, 16'h0000);
        reset = 1'b0;
        tick();

        // Preload sram[0x0012] through the debug port, then a ctrl debug write
        dbg_we = 1'b1; dbg_waddr = 16'h0012; dbg_wdata = 16'hBEEF;
        tick();
        check("dbg_sram_we", {13'd0, sram_we, vram_we, ctrl_we}, 16'b100);
        check("dbg_waddr",   mem_waddr, 16'h0012);
        check("dbg_wdata",   mem_wdata, 16'hBEEF);
        dbg_waddr = 16'hF003; dbg_wdata = 16'h0007;
        tick();
        check("dbg_ctrl_we", {13'd0, sram_we, vram_we, ctrl_we}, 16'b001);
        check("dbg_ctrl_addr", mem_waddr, 16'hF003);
        dbg_we = 1'b0;
        tick();
        check("dbg_idle_we", {13'd0, sram_we, vram_we, ctrl_we}, 16'b000);

        // Single instruction read from sram
        ins_rd_addr = 16'h0012; ins_rd_req = 1'b1;
        tick();
        check("ins_issue_re",    {15'd0, mem_re}, 16'd1);
        check("ins_issue_raddr", mem_raddr, 16'h0012);
        check("ins_issue_rdy",   {15'd0, ins_rd_rdy}, 16'd0);
        tick();
        check("ins_ret_rdy",  {15'd0, ins_rd_rdy}, 16'd1);
        check("ins_ret_data", ins_rd_data, 16'hBEEF);
        ins_rd_req = 1'b0;
        tick();
        check("ins_after_rdy", {15'd0, ins_rd_rdy}, 16'd0);
        check("ins_after_re",  {15'd0, mem_re}, 16'd0);

        // CPU vram write colliding with a debug sram write
        dat_wr_req = 1'b1; dat_rw_addr = 16'h8005; dat_wr_data = 16'h0041;
        dbg_we = 1'b1; dbg_waddr = 16'h0020; dbg_wdata = 16'h5555;
        tick();
        check("coll_dbg_we",    {13'd0, sram_we, vram_we, ctrl_we}, 16'b100);
        check("coll_dbg_addr",  mem_waddr, 16'h0020);
        check("coll_wr_rdy0",   {15'd0, dat_wr_rdy}, 16'd0);
        dbg_we = 1'b0;
        tick();
        check("coll_cpu_we",    {13'd0, sram_we, vram_we, ctrl_we}, 16'b010);
        check("coll_cpu_addr",  mem_waddr, 16'h8005);
        check("coll_cpu_data",  mem_wdata, 16'h0041);
        check("coll_wr_rdy1",   {15'd0, dat_wr_rdy}, 16'd1);
        dat_wr_req = 1'b0;
        tick();
        check("coll_wr_rdy2",   {15'd0, dat_wr_rdy}, 16'd0);

        // Unmapped write completes with no enable
        dat_wr_req = 1'b1; dat_rw_addr = 16'h4000; dat_wr_data = 16'h9999;
        tick();
        check("unmap_wr_rdy", {15'd0, dat_wr_rdy}, 16'd1);
        check("unmap_we",     {13'd0, sram_we, vram_we, ctrl_we}, 16'b000);
        dat_wr_req = 1'b0;
        tick();

        // Data read from ctrl region returns the fill value without touching RAM
        dat_rw_addr = 16'hF000; dat_rd_req = 1'b1;
        tick();
        check("fill_issue_re",  {15'd0, mem_re}, 16'd0);
        check("fill_issue_rdy", {15'd0, dat_rd_rdy}, 16'd0);
        tick();
        check("fill_rdy",  {15'd0, dat_rd_rdy}, 16'd1);
        check("fill_data", dat_rd_data, 16'hEEEE);
        check("fill_re",   {15'd0, mem_re}, 16'd0);
        dat_rd_req = 1'b0;
        tick();

        // Read and write both requested: write first, read sees the new data
        dat_rw_addr = 16'h0030; dat_wr_data = 16'h1234;
        dat_wr_req = 1'b1; dat_rd_req = 1'b1;
        tick();
        check("raw_wr_rdy", {15'd0, dat_wr_rdy}, 16'd1);
        check("raw_sram_we", {15'd0, sram_we}, 16'd1);
        check("raw_no_re",  {15'd0, mem_re}, 16'd0);
        dat_wr_req = 1'b0;
        tick();
        check("raw_re",    {15'd0, mem_re}, 16'd1);
        check("raw_raddr", mem_raddr, 16'h0030);
        tick();
        check("raw_rd_rdy",  {15'd0, dat_rd_rdy}, 16'd1);
        check("raw_rd_data", dat_rd_data, 16'h1234);
        dat_rd_req = 1'b0;
        tick();

        // Both read sources held: ins grants at k=0,3,..; dat grants at k=1,4,..
        ins_rd_addr = 16'h0012; dat_rw_addr = 16'h0030;
        ins_rd_req = 1'b1; dat_rd_req = 1'b1;
        ins_cnt = 0; dat_cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            check($sformatf("alt_ins_rdy_%0d", k), {15'd0, ins_rd_rdy},
                  (k % 3 == 2) ? 16'd1 : 16'd0);
            check($sformatf("alt_dat_rdy_%0d", k), {15'd0, dat_rd_rdy},
                  (k % 3 == 0) ? 16'd1 : 16'd0);
            if (ins_rd_rdy) begin
                ins_cnt++;
                check("alt_ins_data", ins_rd_data, 16'hBEEF);
            end
            if (dat_rd_rdy) begin
                dat_cnt++;
                check("alt_dat_data", dat_rd_data, 16'h1234);
            end
        end
        ins_rd_req = 1'b0; dat_rd_req = 1'b0;
        check("alt_ins_count", ins_cnt[15:0], 16'd10);
        check("alt_dat_count", dat_cnt[15:0], 16'd10);
        repeat (3) tick();

        // Reset while a read is in flight
        ins_rd_addr = 16'h0012; ins_rd_req = 1'b1;
        tick();
        check("mid_re", {15'd0, mem_re}, 16'd1);
        ins_rd_req = 1'b0; reset = 1'b1;
        tick();
        check("mid_no_rdy", {15'd0, ins_rd_rdy}, 16'd0);
        check("mid_re0",    {15'd0, mem_re}, 16'd0);
        check("mid_raddr0", mem_raddr, 16'h0000);
        check("mid_waddr0", mem_waddr, 16'h0000);
        check("mid_wdata0", mem_wdata, 16'h0000);
        check("mid_we0",    {13'd0, sram_we, vram_we, ctrl_we}, 16'b000);
        reset = 1'b0;
        ins_rd_req = 1'b1; dat_rd_req = 1'b1; dat_rw_addr = 16'h0030;
        tick();
        check("post_re",    {15'd0, mem_re}, 16'd1);
        check("post_raddr", mem_raddr, 16'h0012);
        tick();
        ins_rd_req = 1'b0; dat_rd_req = 1'b0;
        check("post_ins_rdy",  {15'd0, ins_rd_rdy}, 16'd1);
        check("post_ins_data", ins_rd_data, 16'hBEEF);
        check("post_dat_rdy0", {15'd0, dat_rd_rdy}, 16'd0);
        check("post_dat_raddr", mem_raddr, 16'h0030);
        tick();
        check("post_dat_rdy",  {15'd0, dat_rd_rdy}, 16'd1);
        check("post_dat_data", dat_rd_data, 16'h1234);
        check("post_ins_rdy0", {15'd0, ins_rd_rdy}, 16'd0);
        repeat (2) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
